// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbitration slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Rotate-priority selector: first valid requester strictly after last_grant.
// Latency: combinational.
// Backpressure: none; pure function of req_valid and last_grant.
//
// Ports:
//   req_valid  - pending-request vector
//   last_grant - index of the most recently completed grant
//   sel_onehot - one-hot select of the winner (zero when nothing is valid)
//   sel_idx    - index of the winner
//   any_valid  - at least one requester is valid
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] sel_onehot,
  output logic [IDX_W-1:0]   sel_idx,
  output logic               any_valid
);

  int               j;
  logic [IDX_W-1:0] cand;

  // Walk candidates last_grant+1 .. last_grant+NUM_REQ (wrapping), so the
  // previous winner is considered last.
  always_comb begin
    sel_onehot = '0;
    sel_idx    = '0;
    any_valid  = 1'b0;
    j          = 0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last_grant) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IDX_W'(j);
      if (!any_valid && req_valid[cand]) begin
        any_valid        = 1'b1;
        sel_idx          = cand;
        sel_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte clients.
// Latency: req_valid sampled in IDLE -> req_ready/send_request/tx_data one edge later.
// Backpressure: one byte per frame; clients hold req_valid until their req_ready pulse.
//
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   req_valid/req_data/req_cfg     - per-client byte and frame config (packed by index)
//   req_ready                      - one-hot accept pulse
//   baud_tick                      - bit-period pulse (frame timeout only)
//   tx_data/config_bits            - latched byte and config to uart_tx
//   send_request, tx_busy, tx_done - handshake with uart_tx
//   grant_id, active, timeout_err  - status
// Build option: UART_TX_ARBITER_TIMEOUT_EN adds a per-frame baud-tick
// watchdog; without it timeout_err stays 0 and frames wait indefinitely.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int CFG_W         = 1,
  parameter int TIMEOUT_TICKS = 16,
  localparam int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
  input  logic [CFG_W*NUM_REQ-1:0]       req_cfg,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           baud_tick,
  output logic [UART_DATA_W-1:0]         tx_data,
  output logic [CFG_W-1:0]               config_bits,
  output logic                           send_request,
  input  logic                           tx_busy,
  input  logic                           tx_done,
  output logic [IDX_W-1:0]               grant_id,
  output logic                           active,
  output logic                           timeout_err
);

  arb_state_e       state;
  logic [IDX_W-1:0] last_grant;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               timeout_hit;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .sel_onehot (pick_onehot),
    .sel_idx    (pick_idx),
    .any_valid  (pick_any)
  );

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

  logic [CNT_W-1:0] tick_cnt;

  // Fires on the baud tick that would bring the count to TIMEOUT_TICKS.
  assign timeout_hit = baud_tick && (tick_cnt == CNT_W'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (state == IDLE) begin
      if (pick_any) tick_cnt <= '0;
    end else if (baud_tick) begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  wire unused_timeout = baud_tick ^ (TIMEOUT_TICKS > 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      last_grant   <= IDX_W'(NUM_REQ - 1);
      req_ready    <= '0;
      tx_data      <= '0;
      config_bits  <= '0;
      send_request <= 1'b0;
      grant_id     <= '0;
      active       <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      req_ready   <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            req_ready    <= pick_onehot;
            tx_data      <= req_data[UART_DATA_W*int'(pick_idx) +: UART_DATA_W];
            config_bits  <= req_cfg[CFG_W*int'(pick_idx) +: CFG_W];
            grant_id     <= pick_idx;
            send_request <= 1'b1;
            active       <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          // tx_done wins over tx_busy and over a coincident timeout.
          if (tx_done || timeout_hit) begin
            timeout_err  <= !tx_done;
            send_request <= 1'b0;
            active       <= 1'b0;
            last_grant   <= grant_id;
            state        <= IDLE;
          end else if (tx_busy) begin
            send_request <= 1'b0;
            state        <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx_done || timeout_hit) begin
            timeout_err  <= !tx_done;
            send_request <= 1'b0;
            active       <= 1'b0;
            last_grant   <= grant_id;
            state        <= IDLE;
          end
        end
        default: begin
          send_request <= 1'b0;
          active       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a frame-level round-robin model.
// Latency: n/a.
// Backpressure: the bench plays both the clients and the uart_tx handshake.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_cfg;
  logic [N-1:0] req_ready;
  logic         baud_tick;
  logic [7:0]   tx_data;
  logic [0:0]   config_bits;
  logic         send_request;
  logic         tx_busy;
  logic         tx_done;
  logic [1:0]   grant_id;
  logic         active;
  logic         timeout_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_last;
  bit   rand_baud;
  logic [7:0] dat [N];
  logic       cfgv [N];
  logic [7:0] acc_dat;
  logic       acc_cfg;

  uart_tx_arbiter #(
    .NUM_REQ       (N),
    .CFG_W         (1),
    .TIMEOUT_TICKS (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_cfg      (req_cfg),
    .req_ready    (req_ready),
    .baud_tick    (baud_tick),
    .tx_data      (tx_data),
    .config_bits  (config_bits),
    .send_request (send_request),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .grant_id     (grant_id),
    .active       (active),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rand_baud) baud_tick = 1'($urandom_range(0, 1));
  endtask

  // Round robin: first valid index after the last completed grant, wrapping.
  function automatic int pick(input logic [N-1:0] m, input int last);
    for (int k = 1; k <= N; k++) begin
      if (m[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < N; i++) begin
      req_data[8*i +: 8] = dat[i];
      req_cfg[i]         = cfgv[i];
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_data"}, 32'(tx_data), 0);
    chk({tag, "_cfg"}, 32'(config_bits), 0);
    chk({tag, "_sreq"}, 32'(send_request), 0);
    chk({tag, "_gid"}, 32'(grant_id), 0);
    chk({tag, "_active"}, 32'(active), 0);
    chk({tag, "_toerr"}, 32'(timeout_err), 0);
  endtask

  // Present mask with the FSM idle; the accept must land on the first edge.
  task automatic accept(input logic [N-1:0] mask, output int g);
    int waited;
    logic [N-1:0] oh;
    g = pick(mask, model_last);
    oh = N'(1) << g;
    req_valid = mask;
    drive_reqs();
    waited = 0;
    do begin
      tick();
      waited++;
    end while (req_ready == '0 && waited < 8);
    chk("accept_latency", waited, 1);
    chk("req_ready", 32'(req_ready), 32'(oh));
    chk("tx_data", 32'(tx_data), 32'(dat[g]));
    chk("config_bits", 32'(config_bits), 32'(cfgv[g]));
    chk("grant_id", 32'(grant_id), g);
    chk("send_req_rise", 32'(send_request), 1);
    chk("active_rise", 32'(active), 1);
    chk("toerr_quiet", 32'(timeout_err), 0);
    acc_dat = dat[g];
    acc_cfg = cfgv[g];
    // The client is free to move on once its byte is taken.
    dat[g]  = 8'($urandom);
    cfgv[g] = ~cfgv[g];
    drive_reqs();
  endtask

  task automatic finish_frame(input bit done_in_issue, input int busy_dly,
                              input int done_dly, input int g);
    for (int i = 0; i < busy_dly; i++) begin
      tick();
      chk("ready_pulse", 32'(req_ready), 0);
      chk("sreq_hold", 32'(send_request), 1);
    end
    tx_busy = 1'b1;
    tx_done = done_in_issue;
    tick();
    chk("sreq_drop", 32'(send_request), 0);
    chk("data_stable", 32'(tx_data), 32'(acc_dat));
    if (done_in_issue) begin
      tx_busy = 1'b0;
      tx_done = 1'b0;
      chk("idle_after_issue_done", 32'(active), 0);
    end else begin
      chk("active_wait", 32'(active), 1);
      for (int i = 0; i < done_dly; i++) begin
        tick();
        chk("sreq_low_wait", 32'(send_request), 0);
      end
      tx_busy = 1'b0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("idle_after_done", 32'(active), 0);
      chk("sreq_low_done", 32'(send_request), 0);
    end
    chk("cfg_stable", 32'(config_bits), 32'(acc_cfg));
    chk("ready_quiet", 32'(req_ready), 0);
    chk("no_timeout", 32'(timeout_err), 0);
    model_last = g;
  endtask

  initial begin
    int g;
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_cfg   = '0;
    baud_tick = 1'b0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    rand_baud = 1'b0;
    for (int i = 0; i < N; i++) begin
      dat[i]  = 8'h00;
      cfgv[i] = 1'b0;
    end
    tick();
    tick();
    check_zero_outputs("reset");
    reset      = 1'b0;
    model_last = N - 1;
    tick();

    // Single requester 2, byte 0x55, cfg 1, busy after 2 cycles, done 100 later.
    dat[2]  = 8'h55;
    cfgv[2] = 1'b1;
    accept(4'b0100, g);
    chk("directed_gid", 32'(grant_id), 2);
    finish_frame(1'b0, 2, 100, g);

    // Make last_grant 1, then requesters 1 and 3: 3 wins, then 1.
    req_valid = '0;
    accept(4'b0010, g);
    finish_frame(1'b0, 1, 3, g);
    accept(4'b1010, g);
    chk("rr_after1_first", g, 3);
    finish_frame(1'b0, 1, 2, g);
    accept(4'b1010, g);
    chk("rr_after1_second", g, 1);
    finish_frame(1'b0, 2, 2, g);

    // tx_done coincident with tx_busy in ISSUE.
    accept(4'b0001, g);
    finish_frame(1'b1, 1, 0, g);

    // Fresh reset, then all four continuously valid with bytes 0x10+i.
    req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_last = N - 1;
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < N; i++) begin
        dat[i]  = 8'(8'h10 + i);
        cfgv[i] = i[0];
      end
      accept(4'b1111, g);
      chk("cont_order", g, f % N);
      chk("cont_data", 32'(acc_dat), 32'(8'h10 + (f % N)));
      finish_frame(1'b0, 1, 3, g);
    end

`ifndef UART_TX_ARBITER_TIMEOUT_EN
    rand_baud = 1'b1;
`endif
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < N; i++) begin
        dat[i]  = 8'($urandom);
        cfgv[i] = 1'($urandom_range(0, 1));
      end
      accept(N'($urandom_range(1, (1 << N) - 1)), g);
      finish_frame(($urandom_range(0, 3) == 0), $urandom_range(1, 3),
                   $urandom_range(0, 6), g);
    end
    rand_baud = 1'b0;
    baud_tick = 1'b0;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    // No tx_done: abort on the 4th baud tick after accept.
    begin
      int  seen;
      bit  was;
      seen = 0;
      accept(4'b0101, g);
      for (int c = 0; c < 40 && seen < 4; c++) begin
        baud_tick = (c % 3 == 2);
        was = baud_tick;
        tick();
        baud_tick = 1'b0;
        if (was) seen++;
        chk("to_err", 32'(timeout_err), 32'(seen == 4));
        chk("to_active", 32'(active), 32'(seen < 4));
      end
      chk("to_ticks", seen, 4);
      chk("to_sreq", 32'(send_request), 0);
      model_last = g;
      accept(4'b0101, g);
      finish_frame(1'b0, 1, 2, g);
    end
`endif

    // Reset while waiting for tx_done, then 0 and 3 valid: 0 wins.
    accept(4'b0110, g);
    tx_busy = 1'b1;
    tick();
    chk("wait_sreq", 32'(send_request), 0);
    chk("wait_active", 32'(active), 1);
    reset = 1'b1;
    tick();
    check_zero_outputs("midreset");
    reset   = 1'b0;
    tx_busy = 1'b0;
    model_last = N - 1;
    accept(4'b1001, g);
    chk("post_reset_first", g, 0);
    finish_frame(1'b0, 1, 2, g);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
